shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
- Shares one bidirectional 32-bit barrel shifter (left / logical right / arithmetic right) between two requesters.
- Requester 0 is the ALU shift path; requester 1 is the load/store byte-alignment path.
- Arbitrates round-robin, computes the shift combinationally, and registers the result in a single output slot with valid/ready back-pressure.
- Sits beside the execute stage. Fixed 1-cycle latency from accept to result valid.

Parameters:
- WIDTH, 32, data width of operands and result.
- WIDTHDIST, 5, width of shift distance; the full 0..2^WIDTHDIST-1 range is legal.

Ports:
- clock  in  1  single clock; everything is clocked on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_data  in  WIDTH  operand 0.
- req0_distance  in  WIDTHDIST  shift amount 0.
- req0_direction  in  1  0 = left, 1 = right.
- req0_arith  in  1  right shifts only: 1 = sign fill, 0 = zero fill.
- req1_valid, req1_ready, req1_data, req1_distance, req1_direction, req1_arith: same as requester 0, for requester 1.
- res_valid  out  1  output slot holds a result.
- res_ready  in  1  consumer takes the result this cycle.
- res_id  out  1  requester that owns the result.
- res_data  out  WIDTH  shift result.

Behaviour:
- Reset values: res_valid=0, res_id=0, res_data=0, last_grant=1, so requester 0 wins the first tie.
- Reset takes priority over everything. A pending result is discarded, and no request is accepted in a reset cycle (req0_ready=req1_ready=0 while reset=1).
- Slot free: slot_free = !res_valid | res_ready.
- Grant (combinational):
  - If slot_free=0: no grant.
  - If exactly one reqN_valid: grant N.
  - If both valid: grant the requester != last_grant.
- reqN_ready = grant==N. A ready may be asserted only when the matching valid is high. Readies are never both high.
- Accept = valid & ready. On accept:
  - res_valid<=1, res_id<=N, res_data<=shift(reqN operands), last_grant<=N.
- No accept but res_ready=1: res_valid<=0; res_id and res_data hold their values.
- Neither accept nor res_ready: all state holds. Outputs stay stable while res_valid=1 and res_ready=0.
- Throughput: back-to-back accepts every cycle while res_ready stays high.
- last_grant changes only on accept. Idle cycles do not rotate priority.
- Shift function, result truncated to WIDTH:
  - direction=0: data << distance, zero fill; arith is ignored.
  - direction=1, arith=0: data >> distance, zero fill.
  - direction=1, arith=1: every vacated bit equals data[WIDTH-1].
  - distance=0 returns data unchanged in every mode.
- Requester rules: reqN operands must stay stable while valid=1 and ready=0. A requester may drop valid without being accepted; no state is affected.
- Starvation bound: a continuously valid requester is accepted within 2 slot-free cycles.

Test Plan:
- Reset then single request: req0 valid, data=0x98765432, dist=4, dir=1, arith=1, res_ready=1. Required: req0_ready=1 that cycle; next cycle res_valid=1, res_id=0, res_data=0xF9876543.
- Logical vs left: req1 data=0x98765432, dist=4, dir=1, arith=0 -> res_data=0x09876543. Then dir=0, dist=31, data=0x00000003 -> res_data=0x80000000. dist=0 in every mode -> data unchanged.
- Contention round-robin: both valid continuously for 4 cycles, res_ready=1. Required grant order 0,1,0,1; four results in consecutive cycles with res_id 0,1,0,1.
- Back-pressure: result pending with res_ready=0 for 3 cycles while both request. Required: both readies 0, res_data/res_id stable. When res_ready=1, the next grant is accepted in the same cycle and res_valid stays 1 with the new data.
- Reset mid-operation: res_valid=1 and req0 valid when reset=1. Required: next cycle res_valid=0, no ready asserted during reset. First grant after reset goes to requester 0 even if both are valid.
- Arithmetic max distance: data=0x08765432, dist=31, dir=1, arith=1 -> 0x00000000. data=0x80000000, same settings -> 0xFFFFFFFF.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// Handshake bundle for shift_arbiter.
//
// Valid/ready semantics for every channel: a transfer happens on a rising
// clock edge where both valid and ready are high. A producer holds its
// payload stable while valid=1 and ready=0. A requester may withdraw valid
// before it is accepted. The arbiter raises reqN_ready only while reqN_valid
// is high.
//
// Signals:
//   req0_* : requester 0 (ALU shift path): valid, ready, data, distance,
//            direction (0=left, 1=right), arith (right only: 1=sign fill)
//   req1_* : requester 1 (load/store byte alignment), same fields
//   res_*  : registered result slot: valid, ready, id (owner), data
//
// Modports:
//   master : requesters plus result consumer (the testbench / execute stage)
//   slave  : the arbiter
interface shift_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int WIDTHDIST = 5
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_data;
    logic [WIDTHDIST-1:0] req0_distance;
    logic                 req0_direction;
    logic                 req0_arith;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_data;
    logic [WIDTHDIST-1:0] req1_distance;
    logic                 req1_direction;
    logic                 req1_arith;

    logic                 res_valid;
    logic                 res_ready;
    logic                 res_id;
    logic [WIDTH-1:0]     res_data;

    modport master (
        output req0_valid, req0_data, req0_distance, req0_direction, req0_arith,
        input  req0_ready,
        output req1_valid, req1_data, req1_distance, req1_direction, req1_arith,
        input  req1_ready,
        input  res_valid, res_id, res_data,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_distance, req0_direction, req0_arith,
        output req0_ready,
        input  req1_valid, req1_data, req1_distance, req1_direction, req1_arith,
        output req1_ready,
        output res_valid, res_id, res_data,
        input  res_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one 32-bit barrel shifter between the ALU
// shift path (requester 0) and the load/store alignment path (requester 1).
// The shift is computed combinationally from the granted operands and the
// result lands in a single registered slot, giving a fixed one-cycle latency
// from accept to res_valid.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; discards any pending result
//   bus   : shift_arbiter_if.slave (both request channels + result slot)
module shift_arbiter #(
    parameter int WIDTH     = 32,
    parameter int WIDTHDIST = 5
) (
    input  logic           clock,
    input  logic           reset,
    shift_arbiter_if.slave bus
);

    logic                 res_valid_q;
    logic                 res_id_q;
    logic [WIDTH-1:0]     res_data_q;
    logic                 last_grant_q;

    logic                 slot_free;
    logic                 grant_valid;
    logic                 grant_id;

    logic [WIDTH-1:0]     sel_data;
    logic [WIDTHDIST-1:0] sel_distance;
    logic                 sel_direction;
    logic                 sel_arith;
    logic [WIDTH-1:0]     shift_result;

    // The slot can take a new result if it is empty or being drained now.
    assign slot_free = !res_valid_q || bus.res_ready;

    // Grant: single requester wins outright; on contention the one that did
    // not win last time goes. Reset masks every grant so nothing is accepted
    // in a reset cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!reset && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;

    // Operand mux in front of the one shared shifter.
    always_comb begin
        sel_data      = bus.req0_data;
        sel_distance  = bus.req0_distance;
        sel_direction = bus.req0_direction;
        sel_arith     = bus.req0_arith;
        if (grant_id) begin
            sel_data      = bus.req1_data;
            sel_distance  = bus.req1_distance;
            sel_direction = bus.req1_direction;
            sel_arith     = bus.req1_arith;
        end
    end

    // Left shifts ignore arith; arithmetic right replicates the top bit.
    always_comb begin
        shift_result = sel_data << sel_distance;
        if (sel_direction) begin
            if (sel_arith) begin
                shift_result = $unsigned($signed(sel_data) >>> sel_distance);
            end else begin
                shift_result = sel_data >> sel_distance;
            end
        end
    end

    // last_grant only moves on an accept, so idle cycles do not rotate
    // priority. Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_data_q   <= '0;
            last_grant_q <= 1'b1;
        end else if (grant_valid) begin
            res_valid_q  <= 1'b1;
            res_id_q     <= grant_id;
            res_data_q   <= shift_result;
            last_grant_q <= grant_id;
        end else if (bus.res_ready) begin
            res_valid_q  <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;

endmodule
